event_fifo: RTL and testbench

Parametrised synchronous FIFO for spike-event and data buffering between SNN processor pipeline stages. It is the successor to the basic count-based FIFO, and adds:
- ready/valid handshakes on both sides
- selectable first-word-fall-through (FWFT) or registered-output mode
- programmable almost-full/almost-empty thresholds
- occupancy and high-watermark reporting
- sticky overflow diagnostics and synchronous flush

---
 rtl/snp_fifo_pkg.sv | 21 ++
 rtl/event_fifo_out_stage.sv | 56 +++++
 rtl/event_fifo.sv | 144 ++++++++++++++
 tb/tb_event_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snp_fifo_pkg.sv
// Shared constants and helpers for the SNP pipeline FIFOs.
package snp_fifo_pkg;

    localparam int FIFO_FWFT         = 0;
    localparam int FIFO_REGOUT       = 1;
    localparam int AF_OFFSET_DEFAULT = 2;
    localparam int AE_THRESH_DEFAULT = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/event_fifo_out_stage.sv
// Registered output stage: holds the head word and refills it from memory.
module event_fifo_out_stage
    import snp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  out_ready_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  load_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  ov_next_o
);

    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  pop_s;

    assign pop_s       = ov_q && out_ready_i;
    assign load_o      = (!ov_q || out_ready_i) && mem_valid_i && !flush_i;
    assign out_valid_o = ov_q;
    assign out_data_o  = od_q;
    assign ov_next_o   = ov_d;

    // Next state of the output register; flush beats load, load beats pop.
    always_comb begin
        ov_d = ov_q;
        od_d = od_q;
        if (flush_i) begin
            ov_d = 1'b0;
        end else if (load_o) begin
            ov_d = 1'b1;
            od_d = mem_data_i;
        end else if (pop_s) begin
            ov_d = 1'b0;
        end else begin
            ov_d = ov_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ov_q <= 1'b0;
            od_q <= {DATA_WIDTH{1'b0}};
        end else begin
            ov_q <= ov_d;
            od_q <= od_d;
        end
    end

endmodule

// File: rtl/event_fifo.sv
// Synchronous event FIFO with ready/valid handshakes, FWFT or registered head,
// threshold flags, occupancy/watermark reporting and sticky overflow.
module event_fifo
    import snp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH),
    parameter int REG_OUT    = FIFO_FWFT,
    parameter int AF_THRESH  = DEPTH - AF_OFFSET_DEFAULT,
    parameter int AE_THRESH  = AE_THRESH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_stat,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   watermark
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      mcount_q, mcount_d, count_q, count_d, wm_q, wm_d;
    logic                  ovf_q, ovf_d;
    logic                  full_s, mem_valid_s, push_s, rd_s, ov_next_s;

    assign full_s      = (mcount_q == CNT_W'(DEPTH));
    assign mem_valid_s = (mcount_q != {CNT_W{1'b0}});
    assign push_s      = in_valid && !full_s;

    assign in_ready     = !full_s;
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign overflow     = ovf_q;
    assign watermark    = wm_q;

    generate
        if (REG_OUT == FIFO_REGOUT) begin : g_regout
            event_fifo_out_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_out_stage (
                .clk_i       (clk),
                .rst_n_i     (rst_n),
                .flush_i     (flush),
                .out_ready_i (out_ready),
                .mem_valid_i (mem_valid_s),
                .mem_data_i  (mem_q[rd_ptr_q]),
                .load_o      (rd_s),
                .out_valid_o (out_valid),
                .out_data_o  (out_data),
                .ov_next_o   (ov_next_s)
            );
        end else begin : g_fwft
            assign out_valid = mem_valid_s;
            assign out_data  = mem_q[rd_ptr_q];
            assign rd_s      = mem_valid_s && out_ready;
            assign ov_next_s = 1'b0;
        end
    endgenerate

    // Pointer and occupancy next state; flush overrides any push or read.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mcount_d = mcount_q;
        if (flush) begin
            wr_ptr_d = {ADDR_WIDTH{1'b0}};
            rd_ptr_d = {ADDR_WIDTH{1'b0}};
            mcount_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_s) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            mcount_d = mcount_q + CNT_W'(push_s) - CNT_W'(rd_s);
        end
        count_d = mcount_d + CNT_W'(ov_next_s);
    end

    // Statistics next state; a new overflow wins over clr_stat.
    always_comb begin
        ovf_d = ovf_q;
        wm_d  = wm_q;
        if (in_valid && full_s) begin
            ovf_d = 1'b1;
        end else if (clr_stat) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (clr_stat) begin
            wm_d = count_q;
        end else if (count_d > wm_q) begin
            wm_d = count_d;
        end else begin
            wm_d = wm_q;
        end
    end

    // Storage array; contents survive flush and reset.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control and statistics state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q <= {ADDR_WIDTH{1'b0}};
            mcount_q <= {CNT_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            wm_q     <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mcount_q <= mcount_d;
            count_q  <= count_d;
            wm_q     <= wm_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_event_fifo.sv
// Directed bench for event_fifo: one FWFT instance and one registered-output instance.
module tb_event_fifo;

    logic        clk;
    logic        rst_n;

    logic        f_flush, f_clr_stat, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [31:0] f_in_data, f_out_data;
    logic [4:0]  f_count, f_watermark;
    logic        f_almost_full, f_almost_empty, f_overflow;

    logic        r_flush, r_clr_stat, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [31:0] r_in_data, r_out_data;
    logic [4:0]  r_count, r_watermark;
    logic        r_almost_full, r_almost_empty, r_overflow;

    int checks_cnt;
    int errors_cnt;

    event_fifo #(.DATA_WIDTH(32), .DEPTH(16), .REG_OUT(0)) dut_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (f_flush),
        .clr_stat     (f_clr_stat),
        .in_valid     (f_in_valid),
        .in_ready     (f_in_ready),
        .in_data      (f_in_data),
        .out_valid    (f_out_valid),
        .out_ready    (f_out_ready),
        .out_data     (f_out_data),
        .count        (f_count),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .overflow     (f_overflow),
        .watermark    (f_watermark)
    );

    event_fifo #(.DATA_WIDTH(32), .DEPTH(16), .REG_OUT(1)) dut_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (r_flush),
        .clr_stat     (r_clr_stat),
        .in_valid     (r_in_valid),
        .in_ready     (r_in_ready),
        .in_data      (r_in_data),
        .out_valid    (r_out_valid),
        .out_ready    (r_out_ready),
        .out_data     (r_out_data),
        .count        (r_count),
        .almost_full  (r_almost_full),
        .almost_empty (r_almost_empty),
        .overflow     (r_overflow),
        .watermark    (r_watermark)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt = checks_cnt + 1;
        if (obs !== exp) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_cnt  = 0;
        errors_cnt  = 0;
        f_flush     = 1'b0; f_clr_stat = 1'b0; f_in_valid = 1'b0;
        f_out_ready = 1'b0; f_in_data  = 32'h0;
        r_flush     = 1'b0; r_clr_stat = 1'b0; r_in_valid = 1'b0;
        r_out_ready = 1'b0; r_in_data  = 32'h0;
        rst_n       = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_value("rst_in_ready", 32'(f_in_ready), 32'h1);
        check_value("rst_out_valid", 32'(f_out_valid), 32'h0);
        check_value("rst_count", 32'(f_count), 32'h0);
        check_value("rst_af", 32'(f_almost_full), 32'h0);
        check_value("rst_ae", 32'(f_almost_empty), 32'h1);
        check_value("rst_ovf", 32'(f_overflow), 32'h0);
        check_value("rst_wm", 32'(f_watermark), 32'h0);
        check_value("rst_reg_out_data", r_out_data, 32'h0);
        check_value("rst_reg_out_valid", 32'(r_out_valid), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // FWFT fill with the consumer stalled
        for (int i = 0; i < 16; i++) begin
            f_in_valid = 1'b1;
            f_in_data  = 32'(i);
            step();
            check_value("fill_count", 32'(f_count), 32'(i + 1));
            check_value("fill_af", 32'(f_almost_full), 32'((i + 1) >= 14));
            check_value("fill_in_ready", 32'(f_in_ready), 32'((i + 1) < 16));
            if (i == 0) begin
                check_value("fwft_latency_valid", 32'(f_out_valid), 32'h1);
                check_value("fwft_latency_data", f_out_data, 32'h0);
            end
        end
        check_value("fill_wm", 32'(f_watermark), 32'd16);

        // Overflow while full
        for (int i = 0; i < 3; i++) begin
            f_in_valid = 1'b1;
            f_in_data  = 32'hDEAD;
            step();
            check_value("ovf_flag", 32'(f_overflow), 32'h1);
            check_value("ovf_count", 32'(f_count), 32'd16);
            check_value("ovf_head", f_out_data, 32'h0);
        end
        f_in_valid = 1'b0;

        // Drain in order
        f_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_value("drain_valid", 32'(f_out_valid), 32'h1);
            check_value("drain_data", f_out_data, 32'(i));
            step();
            check_value("drain_count", 32'(f_count), 32'(15 - i));
            check_value("drain_ae", 32'(f_almost_empty), 32'((15 - i) <= 2));
        end
        f_out_ready = 1'b0;
        check_value("drain_empty_valid", 32'(f_out_valid), 32'h0);
        check_value("drain_ovf_sticky", 32'(f_overflow), 32'h1);

        f_clr_stat = 1'b1;
        step();
        f_clr_stat = 1'b0;
        check_value("clr_ovf", 32'(f_overflow), 32'h0);
        check_value("clr_wm", 32'(f_watermark), 32'h0);

        // Wrap with concurrent push/pop at occupancy 8
        for (int i = 0; i < 8; i++) begin
            f_in_valid = 1'b1;
            f_in_data  = 32'(100 + i);
            step();
        end
        f_out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            f_in_data = 32'(108 + k);
            check_value("wrap_data", f_out_data, 32'(100 + k));
            step();
            check_value("wrap_count", 32'(f_count), 32'd8);
        end
        f_in_valid = 1'b0;
        check_value("wrap_wm", 32'(f_watermark), 32'd8);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        f_out_ready = 1'b0;
        check_value("pre_flush_count", 32'(f_count), 32'd5);

        // Flush together with push and pop
        f_flush     = 1'b1;
        f_in_valid  = 1'b1;
        f_in_data   = 32'h77;
        f_out_ready = 1'b1;
        step();
        f_flush     = 1'b0;
        f_in_valid  = 1'b0;
        f_out_ready = 1'b0;
        check_value("flush_count", 32'(f_count), 32'h0);
        check_value("flush_valid", 32'(f_out_valid), 32'h0);
        check_value("flush_in_ready", 32'(f_in_ready), 32'h1);
        check_value("flush_ovf", 32'(f_overflow), 32'h0);
        check_value("flush_wm", 32'(f_watermark), 32'd8);
        f_in_valid = 1'b1;
        f_in_data  = 32'h55;
        step();
        f_in_valid = 1'b0;
        check_value("post_flush_data", f_out_data, 32'h55);
        check_value("post_flush_count", 32'(f_count), 32'h1);

        // Asynchronous reset between edges during a burst
        for (int i = 0; i < 3; i++) begin
            f_in_valid = 1'b1;
            f_in_data  = 32'(32'h200 + i);
            step();
        end
        #2 rst_n = 1'b0;
        f_in_valid = 1'b0;
        #1;
        check_value("arst_count", 32'(f_count), 32'h0);
        check_value("arst_valid", 32'(f_out_valid), 32'h0);
        check_value("arst_in_ready", 32'(f_in_ready), 32'h1);
        check_value("arst_wm", 32'(f_watermark), 32'h0);
        check_value("arst_ae", 32'(f_almost_empty), 32'h1);
        step();
        rst_n      = 1'b1;
        f_in_valid = 1'b1;
        f_in_data  = 32'h1;
        step();
        f_in_valid = 1'b0;
        check_value("arst_first_valid", 32'(f_out_valid), 32'h1);
        check_value("arst_first_data", f_out_data, 32'h1);

        // Registered-output latency
        r_in_valid = 1'b1;
        r_in_data  = 32'hA5;
        step();
        r_in_valid = 1'b0;
        check_value("reg_lat_t", 32'(r_out_valid), 32'h0);
        check_value("reg_lat_t_count", 32'(r_count), 32'h1);
        step();
        check_value("reg_lat_t1", 32'(r_out_valid), 32'h1);
        check_value("reg_lat_data", r_out_data, 32'hA5);
        check_value("reg_lat_count", 32'(r_count), 32'h1);

        // Registered-output fill to DEPTH+1
        for (int k = 0; k < 16; k++) begin
            r_in_valid = 1'b1;
            r_in_data  = 32'(k);
            step();
            check_value("reg_fill_count", 32'(r_count), 32'(k + 2));
            check_value("reg_fill_in_ready", 32'(r_in_ready), 32'((k + 2) < 17));
        end
        r_in_valid = 1'b0;
        check_value("reg_fill_af", 32'(r_almost_full), 32'h1);
        check_value("reg_fill_wm", 32'(r_watermark), 32'd17);
        check_value("reg_hold_data", r_out_data, 32'hA5);

        // Registered-output drain at one word per cycle
        r_out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check_value("reg_drain_valid", 32'(r_out_valid), 32'h1);
            check_value("reg_drain_data", r_out_data, (k == 0) ? 32'hA5 : 32'(k - 1));
            step();
            check_value("reg_drain_count", 32'(r_count), 32'(16 - k));
        end
        r_out_ready = 1'b0;
        check_value("reg_drain_empty", 32'(r_out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
